sc_song_sequencer: RTL
======================

Name: sc_song_sequencer

Overview:
- Session controller for the scoring datapath.
- Generates the millisecond song_time base consumed by note matching and serialization, and owns the pause flag.
- Gates the score accumulator enable and pulses a score clear at session start.
- Sequences one song: idle -> countdown -> play (with pause/resume) -> done, plus abort at any time.

Parameters:
- CLK_PER_MS, 100000, clk cycles per song millisecond (100 MHz clk)
- COUNTDOWN_MS, 3000, pre-roll length in ms before song_time starts
- TIME_W, 16, width of song_time, song_len and cd_ms

Ports:
- clk  in  1  100 MHz system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begin session (valid in IDLE or DONE)
- pause_req  in  1  one-cycle pulse; toggle PLAYING <-> PAUSED
- abort  in  1  one-cycle pulse; return to IDLE from any state
- song_len  in  TIME_W  song length in ms, sampled on an accepted start
- song_time  out  TIME_W  current song time in ms, registered
- pause  out  1  high while in PAUSED
- sc_en  out  1  scoring enable, high only in PLAYING
- score_clear  out  1  one-cycle pulse on an accepted start
- cd_ms  out  TIME_W  remaining countdown ms; 0 outside COUNTDOWN
- done  out  1  one-cycle pulse on entry to DONE
- state  out  3  IDLE=0, COUNTDOWN=1, PLAYING=2, PAUSED=3, DONE=4

Behaviour:
- Reset (sync, highest priority): state=IDLE; song_time=0, cd_ms=0, prescaler=0; pause, sc_en, score_clear, done all 0. Reset mid-song behaves the same, with no done pulse.
- Prescaler:
  - Counts 0..CLK_PER_MS-1 only in COUNTDOWN and PLAYING.
  - tick = (prescaler == CLK_PER_MS-1); the counter wraps to 0 on tick.
  - Holds its value in PAUSED, so sub-ms phase is preserved across a pause.
  - Cleared in IDLE and DONE, and on any accepted start.
- Input priority per cycle: rst > abort > start > tick/done evaluation > pause_req.
- IDLE:
  - start -> COUNTDOWN.
  - On the same edge: latch song_len, cd_ms=COUNTDOWN_MS, song_time=0, score_clear=1 for exactly one cycle.
  - pause_req ignored.
- COUNTDOWN:
  - Each tick: cd_ms -= 1.
  - On the tick where cd_ms==1: cd_ms=0, song_time=0, -> PLAYING.
  - COUNTDOWN_MS=0: start goes directly to PLAYING. score_clear still pulses.
  - pause_req and start ignored.
- PLAYING (sc_en=1):
  - Each tick: song_time += 1.
  - On the tick where song_time+1 >= latched len: song_time=len, -> DONE, done=1 for one cycle.
  - len=0: PLAYING -> DONE on the first cycle in PLAYING, with no tick needed and song_time=0.
  - song_time never exceeds len and saturates at 2^TIME_W-1.
  - pause_req -> PAUSED. If the same cycle has a tick, the increment is applied first.
  - If a tick completes the song in the same cycle as pause_req, DONE wins and pause_req is dropped.
- PAUSED (pause=1, sc_en=0):
  - song_time and prescaler frozen.
  - pause_req -> PLAYING. The first subsequent tick occurs CLK_PER_MS-prescaler_held cycles after resume.
  - start ignored.
- DONE:
  - song_time holds len; sc_en=0.
  - start = restart, handled identically to start in IDLE.
  - pause_req ignored.
- abort (any state other than IDLE):
  - -> IDLE next edge: song_time=0, cd_ms=0, prescaler=0, no done pulse.
  - abort together with start in IDLE: abort wins, stay IDLE.
- All outputs registered. State change is visible in the same cycle as the updated song_time and cd_ms, one clk after the causing input or tick.
- Width rules: counters unsigned TIME_W bits; prescaler width is clog2(CLK_PER_MS).

Test Plan:
- Params for all tests: CLK_PER_MS=4, COUNTDOWN_MS=3.
- Basic sequence: rst then start with song_len=5.
  - score_clear high for 1 cycle.
  - cd_ms steps 3,2,1 every 4 cycles, then PLAYING with song_time=0.
  - song_time reaches 5 after 20 more cycles.
  - done pulses once, state=4, sc_en drops.
- Pause/resume: pause_req 2 cycles after a tick at song_time=2.
  - pause=1, sc_en=0, song_time holds 2 for 50 cycles.
  - pause_req again -> song_time=3 exactly 2 cycles after resume.
- Edge collisions:
  - song_len=0: start -> after 12 countdown cycles, PLAYING for 1 cycle, then DONE with song_time=0 and one done pulse.
  - pause_req on the final tick of song_len=5: state goes to DONE, not PAUSED.
- Abort and reset:
  - abort while PAUSED at song_time=3 -> IDLE, song_time=0, no done pulse.
  - rst asserted mid-COUNTDOWN -> all outputs return to reset values on the next edge.
- Start handling:
  - start while PLAYING is ignored: score_clear stays 0, song_time continues.
  - start in DONE restarts: countdown reloads cd_ms=3, score_clear pulses.
  - start and abort in the same IDLE cycle: stays IDLE.

Source files
------------

// File: rtl/sc_song_sequencer.sv
// Song session controller: countdown pre-roll, millisecond song_time base,
// pause/resume, score gating and abort for one song at a time.
module sc_song_sequencer #(
    parameter int CLK_PER_MS   = 100000,
    parameter int COUNTDOWN_MS = 3000,
    parameter int TIME_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              pause_req,
    input  logic              abort,
    input  logic [TIME_W-1:0] song_len,
    output logic [TIME_W-1:0] song_time,
    output logic              pause,
    output logic              sc_en,
    output logic              score_clear,
    output logic [TIME_W-1:0] cd_ms,
    output logic              done,
    output logic [2:0]        state
);

    localparam int                PS_W    = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam logic [PS_W-1:0]   PS_MAX  = PS_W'(CLK_PER_MS - 1);
    localparam logic [PS_W-1:0]   PS_ONE  = PS_W'(1);
    localparam logic [TIME_W-1:0] CD_LOAD = TIME_W'(COUNTDOWN_MS);
    localparam logic [TIME_W-1:0] T_ONE   = TIME_W'(1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_PLAYING   = 3'd2,
        S_PAUSED    = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t              r_state;
    logic [PS_W-1:0]     r_prescaler;
    logic [TIME_W-1:0]   r_song_time;
    logic [TIME_W-1:0]   r_cd_ms;
    logic [TIME_W-1:0]   r_len;
    logic                r_pause;
    logic                r_sc_en;
    logic                r_score_clear;
    logic                r_done;

    logic                w_counting;
    logic                w_tick;
    logic                w_start_ok;
    logic [TIME_W:0]     w_song_inc;
    logic                w_song_end;
    logic [PS_W-1:0]     w_prescaler_nxt;

    // The prescaler only runs while the song clock is live; PAUSED freezes it.
    assign w_counting      = (r_state == S_COUNTDOWN) || (r_state == S_PLAYING);
    assign w_tick          = w_counting && (r_prescaler == PS_MAX);
    assign w_prescaler_nxt = w_tick ? '0 : r_prescaler + PS_ONE;
    assign w_start_ok      = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_song_inc      = {1'b0, r_song_time} + {{TIME_W{1'b0}}, 1'b1};
    assign w_song_end      = (w_song_inc >= {1'b0, r_len});

    always_ff @(posedge clk) begin
        // NOTE: pulse outputs default low every cycle; any later assignment in this block overrides it.
        r_score_clear <= 1'b0;
        r_done        <= 1'b0;
        if (rst) begin
            r_state     <= S_IDLE;
            r_prescaler <= '0;
            r_song_time <= '0;
            r_cd_ms     <= '0;
            r_len       <= '0;
            r_pause     <= 1'b0;
            r_sc_en     <= 1'b0;
        end else if (abort) begin
            r_state     <= S_IDLE;
            r_prescaler <= '0;
            r_song_time <= '0;
            r_cd_ms     <= '0;
            r_pause     <= 1'b0;
            r_sc_en     <= 1'b0;
        end else if (w_start_ok) begin
            r_len         <= song_len;
            r_prescaler   <= '0;
            r_song_time   <= '0;
            r_score_clear <= 1'b1;
            r_pause       <= 1'b0;
            if (COUNTDOWN_MS == 0) begin
                r_state <= S_PLAYING;
                r_cd_ms <= '0;
                r_sc_en <= 1'b1;
            end else begin
                r_state <= S_COUNTDOWN;
                r_cd_ms <= CD_LOAD;
                r_sc_en <= 1'b0;
            end
        end else begin
            case (r_state)
                S_COUNTDOWN: begin
                    r_prescaler <= w_prescaler_nxt;
                    if (w_tick) begin
                        if (r_cd_ms == T_ONE) begin
                            r_cd_ms     <= '0;
                            r_song_time <= '0;
                            r_state     <= S_PLAYING;
                            r_sc_en     <= 1'b1;
                        end else begin
                            r_cd_ms <= r_cd_ms - T_ONE;
                        end
                    end
                end
                S_PLAYING: begin
                    // Completion beats a same-cycle pause request.
                    if ((r_len == '0) || (w_tick && w_song_end)) begin
                        r_song_time <= r_len;
                        r_prescaler <= '0;
                        r_state     <= S_DONE;
                        r_sc_en     <= 1'b0;
                        r_done      <= 1'b1;
                    end else begin
                        r_prescaler <= w_prescaler_nxt;
                        if (w_tick) begin
                            r_song_time <= w_song_inc[TIME_W-1:0];
                        end
                        if (pause_req) begin
                            r_state <= S_PAUSED;
                            r_pause <= 1'b1;
                            r_sc_en <= 1'b0;
                        end
                    end
                end
                S_PAUSED: begin
                    if (pause_req) begin
                        r_state <= S_PLAYING;
                        r_pause <= 1'b0;
                        r_sc_en <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign song_time   = r_song_time;
    assign pause       = r_pause;
    assign sc_en       = r_sc_en;
    assign score_clear = r_score_clear;
    assign cd_ms       = r_cd_ms;
    assign done        = r_done;
    assign state       = r_state;

endmodule
